// File: rtl/mult_fu_stage.sv
// mult_fu_stage: pipelined 32x32 multiplier functional unit (RV32M MUL/MULH/MULHSU/MULHU).
//
// Operands are extended to 64 bits at issue. The product is accumulated one
// multiplier slice of W = 64/MULT_STAGES bits per stage. A final output
// register holds the result until the complete stage takes it.
//
// Handshake: a packet is accepted at a rising edge when fu_pkt_in.valid and
// fu_ready are both 1. The output retires at an edge where fu_c_pkt.valid is 1
// and complete_stall is 0. fu_ready = advance = !(output valid && complete_stall).
// It is forced low while rst is high. When advance is 0, the whole pipe holds.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   fu_pkt_in         issue packet (ISSUE_FU_PACKET)
//   complete_stall    complete stage refuses the result this cycle
//   squash            branch-recovery flush (honoured only with MULT_FU_SQUASH_EN)
//   fu_ready          this FU can accept a packet this cycle
//   want_to_complete  result available (equals fu_c_pkt.valid)
//   fu_c_pkt          result packet (FU_COMPLETE_PACKET), all-zero when invalid
//
// Optional feature macro: MULT_FU_SQUASH_EN. When it is defined, squash clears
// every valid bit, and squash has priority over complete_stall.

package mult_fu_pkg;
  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mult_func_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] PC;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [5:0]  dest_pr;
    logic [4:0]  rob_entry;
    mult_func_t  mult_func;
  } ISSUE_FU_PACKET;

  typedef struct packed {
    logic        valid;
    logic [31:0] PC;
    logic [5:0]  dest_pr;
    logic [4:0]  rob_entry;
    logic [31:0] dest_value;
  } FU_COMPLETE_PACKET;
endpackage

module mult_fu_stage
  import mult_fu_pkg::*;
#(
  parameter int MULT_STAGES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  ISSUE_FU_PACKET    fu_pkt_in,
  input  logic              complete_stall,
  input  logic              squash,
  output logic              fu_ready,
  output logic              want_to_complete,
  output FU_COMPLETE_PACKET fu_c_pkt
);

  localparam int W = 64 / MULT_STAGES;

  // acc holds the sum of partial products for slices 0..k after stage k.
  typedef struct packed {
    logic        valid;
    logic [31:0] PC;
    logic [5:0]  dest_pr;
    logic [4:0]  rob_entry;
    mult_func_t  func;
    logic [63:0] mcand;
    logic [63:0] mplier;
    logic [63:0] acc;
  } stage_t;

  stage_t            stage_q [MULT_STAGES];
  stage_t            stage_d [MULT_STAGES];
  FU_COMPLETE_PACKET out_q;
  FU_COMPLETE_PACKET out_d;
  logic              advance;
  logic [63:0]       in_mcand;
  logic [63:0]       in_mplier;

  assign advance          = !(out_q.valid && complete_stall);
  assign fu_ready         = advance && !rst;
  assign want_to_complete = out_q.valid;
  assign fu_c_pkt         = out_q;

  function automatic logic [63:0] extend(input logic [31:0] v, input logic sgn);
    return {{32{sgn & v[31]}}, v};
  endfunction

  // rs1 is signed for MULH/MULHSU. rs2 is signed only for MULH.
  always_comb begin
    in_mcand  = extend(fu_pkt_in.rs1_value,
                       (fu_pkt_in.mult_func == MULH) || (fu_pkt_in.mult_func == MULHSU));
    in_mplier = extend(fu_pkt_in.rs2_value, fu_pkt_in.mult_func == MULH);
  end

  // Next-state values for every stage. Stage 0 folds in the lowest slice at issue.
  // Later stages add their own slice, shifted into position. Bubbles flow through
  // unchanged apart from the (irrelevant) accumulator update.
  always_comb begin
    stage_d[0]           = '0;
    stage_d[0].valid     = fu_pkt_in.valid;
    stage_d[0].PC        = fu_pkt_in.PC;
    stage_d[0].dest_pr   = fu_pkt_in.dest_pr;
    stage_d[0].rob_entry = fu_pkt_in.rob_entry;
    stage_d[0].func      = fu_pkt_in.mult_func;
    stage_d[0].mcand     = in_mcand;
    stage_d[0].mplier    = in_mplier;
    stage_d[0].acc       = in_mcand * 64'(in_mplier[W-1:0]);
    for (int k = 1; k < MULT_STAGES; k++) begin
      stage_d[k]     = stage_q[k-1];
      stage_d[k].acc = stage_q[k-1].acc +
                       ((stage_q[k-1].mcand * 64'(stage_q[k-1].mplier[k*W +: W])) << (k*W));
    end
  end

  // Output register content. A bubble in the last stage produces an all-zero packet.
  always_comb begin
    out_d = '0;
    if (stage_q[MULT_STAGES-1].valid) begin
      out_d.valid      = 1'b1;
      out_d.PC         = stage_q[MULT_STAGES-1].PC;
      out_d.dest_pr    = stage_q[MULT_STAGES-1].dest_pr;
      out_d.rob_entry  = stage_q[MULT_STAGES-1].rob_entry;
      out_d.dest_value = (stage_q[MULT_STAGES-1].func == MUL) ?
                         stage_q[MULT_STAGES-1].acc[31:0] :
                         stage_q[MULT_STAGES-1].acc[63:32];
    end
  end

`ifndef MULT_FU_SQUASH_EN
  logic squash_unused;
  assign squash_unused = squash;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MULT_STAGES; k++) begin
        stage_q[k] <= '0;
      end
      out_q <= '0;
    end
`ifdef MULT_FU_SQUASH_EN
    else if (squash) begin
      for (int k = 0; k < MULT_STAGES; k++) begin
        stage_q[k].valid <= 1'b0;
      end
      out_q <= '0;
    end
`endif
    else if (advance) begin
      for (int k = 0; k < MULT_STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
      out_q <= out_d;
    end
  end

endmodule

// File: tb/tb_mult_fu_stage.sv
// tb_mult_fu_stage: self-checking bench for mult_fu_stage (MULT_STAGES = 4).
// Inputs are driven on the falling edge. Outputs are sampled 2 time units later,
// which is still before the next rising edge. A monitor retires results into the
// scoreboard queue. Scenario tasks add their own latency checks and value checks.
module tb_mult_fu_stage;
  import mult_fu_pkg::*;

  localparam int STAGES = 4;
  localparam int EW     = 75;  // {PC, dest_pr, rob_entry, dest_value}

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  ISSUE_FU_PACKET    pkt_in;
  logic              complete_stall;
  logic              squash;
  logic              fu_ready;
  logic              want;
  FU_COMPLETE_PACKET c_pkt;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [EW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mult_fu_stage #(.MULT_STAGES(STAGES)) dut (
    .clk              (clk),
    .rst              (rst),
    .fu_pkt_in        (pkt_in),
    .complete_stall   (complete_stall),
    .squash           (squash),
    .fu_ready         (fu_ready),
    .want_to_complete (want),
    .fu_c_pkt         (c_pkt)
  );

  // ---------------- reference model ----------------
  // This is the 64-bit product of the operands, each read as signed or unsigned
  // according to the operation.
  function automatic logic [31:0] ref_result(input mult_func_t f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint x, y, p;
    x = (f == MULH || f == MULHSU) ? longint'($signed(a)) : longint'({32'b0, a});
    y = (f == MULH) ? longint'($signed(b)) : longint'({32'b0, b});
    p = x * y;
    return (f == MUL) ? p[31:0] : p[63:32];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic put_op(input mult_func_t f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [5:0] dp, input logic [4:0] rob,
                        input bit push);
    pkt_in.valid     = 1'b1;
    pkt_in.PC        = pc;
    pkt_in.rs1_value = a;
    pkt_in.rs2_value = b;
    pkt_in.dest_pr   = dp;
    pkt_in.rob_entry = rob;
    pkt_in.mult_func = f;
    if (push) exp_q.push_back({pc, dp, rob, ref_result(f, a, b)});
  endtask

  task automatic put_idle();
    pkt_in = '0;
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [5];
    corners[0] = 32'h0;
    corners[1] = 32'h1;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    #2;
    tests_run++;
    if (want !== c_pkt.valid) begin
      tests_failed++;
      $display("FAIL want_to_complete: got %b, expected %b", want, c_pkt.valid);
    end
    tests_run++;
    if (fu_ready !== (!rst && !(c_pkt.valid && complete_stall))) begin
      tests_failed++;
      $display("FAIL fu_ready: got %b, expected %b", fu_ready,
               !rst && !(c_pkt.valid && complete_stall));
    end
    if (c_pkt.valid !== 1'b1) begin
      tests_run++;
      if (c_pkt !== '0) begin
        tests_failed++;
        $display("FAIL idle_zero: got %h, expected 0", c_pkt);
      end
    end else if (!complete_stall) begin
      tests_run++;
      got = {c_pkt.PC, c_pkt.dest_pr, c_pkt.rob_entry, c_pkt.dest_value};
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_result: got %h, expected none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          tests_failed++;
          $display("FAIL result: got %h, expected %h", got, e);
        end
      end
    end
  end

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    #1;
    tests_run++;
    if (c_pkt !== '0 || want !== 1'b0 || fu_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: pkt=%h want=%b ready=%b, expected 0/0/0", c_pkt, want, fu_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #2;
    tests_run++;
    if (fu_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ready_after_reset: got %b, expected 1", fu_ready);
    end
  endtask

  // This issues one operation at edge 0. The result must be invisible after
  // edges 0..3 and visible after edge 4.
  task automatic run_one(input string name, input mult_func_t f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expv);
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i == 0) put_op(f, a, b, 32'h0000_1000 + 32'(i), 6'd17, 5'd9, 1'b1);
      else put_idle();
      #2;
      if (i >= 1 && i <= 4) begin
        tests_run++;
        if (c_pkt.valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s_early: cycle %0d valid got %b, expected 0", name, i, c_pkt.valid);
        end
      end
      if (i == 5) begin
        tests_run++;
        if (c_pkt.valid !== 1'b1 || c_pkt.dest_value !== expv || c_pkt.PC !== 32'h0000_1000 ||
            c_pkt.dest_pr !== 6'd17 || c_pkt.rob_entry !== 5'd9) begin
          tests_failed++;
          $display("FAIL %s: got v=%b val=%h pc=%h pr=%0d rob=%0d, expected v=1 val=%h pc=00001000 pr=17 rob=9",
                   name, c_pkt.valid, c_pkt.dest_value, c_pkt.PC, c_pkt.dest_pr, c_pkt.rob_entry, expv);
        end
      end
    end
  endtask

  task automatic test_basic_mul();
    run_one("mul_7x6", MUL, 32'd7, 32'd6, 32'd42);
  endtask

  task automatic test_funcs();
    run_one("mulh", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_one("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_one("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
  endtask

  task automatic test_back_to_back();
    logic [31:0] expv;
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      if (i < 4) put_op(MUL, 32'(i + 1), 32'(i + 1), 32'h2000 + 32'(i), 6'(i), 5'(i), 1'b1);
      else put_idle();
      #2;
      if (i >= 5 && i <= 8) begin
        expv = 32'((i - 4) * (i - 4));
        tests_run++;
        if (c_pkt.valid !== 1'b1 || c_pkt.dest_value !== expv) begin
          tests_failed++;
          $display("FAIL b2b_%0d: got v=%b val=%0d, expected v=1 val=%0d",
                   i - 4, c_pkt.valid, c_pkt.dest_value, expv);
        end
      end
      if (i == 9) begin
        tests_run++;
        if (c_pkt.valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_tail: got valid %b, expected 0", c_pkt.valid);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] a_val;
    logic [31:0] b_val;
    a_val = ref_result(MUL, 32'd123, 32'd456);
    b_val = ref_result(MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      complete_stall = (i >= 5 && i <= 7);
      if (i == 0) put_op(MUL, 32'd123, 32'd456, 32'h3000, 6'd1, 5'd1, 1'b1);
      else if (i == 1) put_op(MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 32'h3004, 6'd2, 5'd2, 1'b1);
      else if (i == 6) put_op(MUL, 32'd9, 32'd9, 32'h3008, 6'd3, 5'd3, 1'b0);  // must be ignored
      else put_idle();
      #2;
      if (i >= 5 && i <= 7) begin
        tests_run++;
        if (c_pkt.valid !== 1'b1 || c_pkt.dest_value !== a_val || fu_ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL stall_hold_%0d: got v=%b val=%h ready=%b, expected v=1 val=%h ready=0",
                   i, c_pkt.valid, c_pkt.dest_value, fu_ready, a_val);
        end
      end
      if (i == 8) begin
        tests_run++;
        if (c_pkt.valid !== 1'b1 || c_pkt.dest_value !== a_val || fu_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL stall_release: got v=%b val=%h ready=%b, expected v=1 val=%h ready=1",
                   c_pkt.valid, c_pkt.dest_value, fu_ready, a_val);
        end
      end
      if (i == 9) begin
        tests_run++;
        if (c_pkt.valid !== 1'b1 || c_pkt.dest_value !== b_val || c_pkt.PC !== 32'h3004) begin
          tests_failed++;
          $display("FAIL stall_next: got v=%b val=%h pc=%h, expected v=1 val=%h pc=00003004",
                   c_pkt.valid, c_pkt.dest_value, c_pkt.PC, b_val);
        end
      end
      if (i == 10) begin
        tests_run++;
        if (c_pkt.valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL stall_no_dup: got valid %b, expected 0", c_pkt.valid);
        end
      end
    end
    complete_stall = 1'b0;
  endtask

  task automatic test_squash();
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      squash = (i == 2);
      if (i == 0) put_op(MUL, 32'd11, 32'd3, 32'h4000, 6'd4, 5'd4, 1'b1);
      else if (i == 1) put_op(MULH, 32'hFFFF_FFF0, 32'd5, 32'h4004, 6'd5, 5'd5, 1'b1);
`ifdef MULT_FU_SQUASH_EN
      else if (i == 2) begin
        put_op(MUL, 32'd2, 32'd2, 32'h4008, 6'd6, 5'd6, 1'b0);
        exp_q.delete();
      end
`else
      else if (i == 2) put_op(MUL, 32'd2, 32'd2, 32'h4008, 6'd6, 5'd6, 1'b1);
`endif
      else put_idle();
      #2;
`ifdef MULT_FU_SQUASH_EN
      if (i >= 3) begin
        tests_run++;
        if (want !== 1'b0) begin
          tests_failed++;
          $display("FAIL squash_kill_%0d: got want %b, expected 0", i, want);
        end
      end
`else
      if (i >= 5 && i <= 7) begin
        tests_run++;
        if (want !== 1'b1) begin
          tests_failed++;
          $display("FAIL squash_ignored_%0d: got want %b, expected 1", i, want);
        end
      end
`endif
    end
    squash = 1'b0;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL squash_drain: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      complete_stall = (i == 5);
      if (i == 0) put_op(MUL, 32'd100, 32'd200, 32'h5000, 6'd7, 5'd7, 1'b1);
      else if (i == 2) put_op(MULHU, 32'hCAFE_0000, 32'h0BAD_0000, 32'h5004, 6'd8, 5'd8, 1'b1);
      else put_idle();
      #2;
    end
    tests_run++;
    if (c_pkt.valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_pre_valid: got %b, expected 1", c_pkt.valid);
    end
    #1 rst = 1'b1;  // between edges
    #1;
    exp_q.delete();
    tests_run++;
    if (c_pkt !== '0 || fu_ready !== 1'b0 || want !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_async: pkt=%h ready=%b want=%b, expected 0/0/0", c_pkt, fu_ready, want);
    end
    @(negedge clk);
    put_op(MUL, 32'd5, 32'd5, 32'h5008, 6'd9, 5'd9, 1'b0);  // presented during reset
    @(negedge clk);
    rst = 1'b0;
    complete_stall = 1'b0;
    put_idle();
    #2;
    tests_run++;
    if (fu_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_release_ready: got %b, expected 1", fu_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #2;
      tests_run++;
      if (want !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_stale_%0d: got want %b, expected 0", i, want);
      end
    end
  endtask

  task automatic test_random();
    int budget;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      complete_stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) != 0) begin
        pkt_in.valid     = 1'b1;
        pkt_in.PC        = $urandom;
        pkt_in.rs1_value = pick_operand();
        pkt_in.rs2_value = pick_operand();
        pkt_in.dest_pr   = 6'($urandom_range(0, 63));
        pkt_in.rob_entry = 5'($urandom_range(0, 31));
        pkt_in.mult_func = mult_func_t'($urandom_range(0, 3));
      end else begin
        put_idle();
      end
      #1;
      if (pkt_in.valid && fu_ready)
        exp_q.push_back({pkt_in.PC, pkt_in.dest_pr, pkt_in.rob_entry,
                         ref_result(pkt_in.mult_func, pkt_in.rs1_value, pkt_in.rs2_value)});
    end
    @(negedge clk);
    complete_stall = 1'b0;
    put_idle();
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(negedge clk);
      #3;
      budget++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL random_drain: got %0d pending after %0d cycles, expected 0", exp_q.size(), budget);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    pkt_in         = '0;
    complete_stall = 1'b0;
    squash         = 1'b0;
    test_reset();
    test_basic_mul();
    test_funcs();
    test_back_to_back();
    test_stall();
    test_squash();
    test_async_reset();
    test_random();
    repeat (2) @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
